// File: rtl/led_anim_seq.sv
// LED animation sequencer: steps a 7-bit frame index through an external pattern ROM
// at (speed+1)*TICK_BASE clocks per frame, with pause, reverse, loop and one-shot play.
module led_anim_seq #(
   parameter int unsigned TICK_BASE = 1000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       stop,
   input  logic       pause,
   input  logic       dir,
   input  logic       loop,
   input  logic [3:0] speed,
   input  logic [1:0] pat_in,
   input  logic [6:0] rom_data,
   output logic [6:0] frame,
   output logic [1:0] pat_sel,
   output logic [6:0] led,
   output logic       busy,
   output logic       done
);

   localparam int unsigned   PW        = (TICK_BASE > 1) ? $clog2(TICK_BASE) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_BASE - 1);

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

   state_t        state_q;
   logic [PW-1:0] presc_q, presc_d;
   logic [3:0]    step_q, step_d;
   logic [3:0]    speed_q;
   logic [6:0]    frame_q, frame_d;
   logic [6:0]    led_q;
   logic [1:0]    pat_sel_q;
   logic          dir_q, loop_q;
   logic          busy_q, done_q;
   logic          base_tick, adv, at_end;

   // Timing chain and candidate next frame; only committed by the FSM while in RUN.
   always_comb begin
      base_tick = (presc_q == PRESC_MAX);
      presc_d   = base_tick ? '0 : presc_q + 1'b1;
      adv       = base_tick && (step_q == speed_q);
      if (adv)
         step_d = '0;
      else if (base_tick)
         step_d = step_q + 1'b1;
      else
         step_d = step_q;
      at_end  = dir_q ? (frame_q == 7'h00) : (frame_q == 7'h7F);
      frame_d = dir_q ? frame_q - 1'b1 : frame_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         frame_q   <= '0;
         pat_sel_q <= '0;
         led_q     <= '1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         presc_q   <= '0;
         step_q    <= '0;
         dir_q     <= 1'b0;
         loop_q    <= 1'b0;
         speed_q   <= '0;
      end else begin
         done_q <= 1'b0;
         led_q  <= (state_q == RUN || state_q == PAUSE) ? rom_data : 7'h7F;
         if (stop) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
         end else if (start) begin
            dir_q     <= dir;
            loop_q    <= loop;
            speed_q   <= speed;
            pat_sel_q <= pat_in;
            frame_q   <= dir ? 7'h7F : 7'h00;
            presc_q   <= '0;
            step_q    <= '0;
            state_q   <= RUN;
            busy_q    <= 1'b1;
         end else begin
            unique case (state_q)
               RUN: begin
                  presc_q <= presc_d;
                  step_q  <= step_d;
                  // One-shot end: frame holds its final index and the done pulse wins over pause.
                  if (adv && at_end && !loop_q) begin
                     state_q <= DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     if (adv)
                        frame_q <= frame_d;
                     if (pause)
                        state_q <= PAUSE;
                  end
               end
               PAUSE: begin
                  if (!pause)
                     state_q <= RUN;
               end
               DONE: begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
               default: ;
            endcase
         end
      end
   end

   assign frame   = frame_q;
   assign pat_sel = pat_sel_q;
   assign led     = led_q;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule
